// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register.
// Issues in-order word fetches and buffers responses until IF/ID takes them.
module if_prefetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ifid_write,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t MAXO_C  = cnt_t'(MAX_OUTST);

    typedef enum logic {
        S_FETCH,
        S_DISCARD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    cnt_t occ;
    logic gnt_ok;
    logic rv_ok;
    logic drop_rsp;
    logic push;
    logic pop;

    // Handshake qualifiers; a response with nothing outstanding is ignored.
    always_comb begin
        occ      = count_q + outst_q;
        imem_req = !reset && !redirect_valid
                   && (outst_q < MAXO_C) && (occ < DEPTH_C);
        gnt_ok   = imem_req && imem_gnt;
        rv_ok    = imem_rvalid && (outst_q != '0);
        drop_rsp = rv_ok && (state_q == S_DISCARD);
        push     = rv_ok && !drop_rsp && !redirect_valid;
        pop      = out_valid && ifid_write && !redirect_valid;
    end

    assign imem_addr = fetch_pc_q;

    // Head presentation; zeros form a bubble when the queue is empty.
    always_comb begin
        out_valid   = !reset && (count_q != '0);
        out_pc      = '0;
        out_instr   = '0;
        out_next_pc = '0;
        if (out_valid) begin
            out_pc      = pc_mem[rd_ptr_q];
            out_instr   = instr_mem[rd_ptr_q];
            out_next_pc = pc_mem[rd_ptr_q] + 32'd4;
        end
    end

    // Next-state: redirect flushes the queue and turns all in-flight fetches into drops.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;

        if (gnt_ok) begin
            outst_d    = outst_d + cnt_t'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rv_ok) begin
            outst_d = outst_d - cnt_t'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_d;
        end else begin
            if (drop_rsp) begin
                drop_d = drop_q - cnt_t'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + ptr_t'(1);
                resp_pc_d = resp_pc_q + 32'd4;
                count_d   = count_d + cnt_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
                count_d  = count_d - cnt_t'(1);
            end
        end

        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid && (outst_d != '0)) begin
                    state_d = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (drop_d == '0) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    // Entry storage; occupancy is tracked by the control registers.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomized bench for if_prefetch_queue.
// A transaction-level model predicts fetches, drops and the output stream.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clock;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_write;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUTST(MAXO),
        .RESET_PC (32'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .ifid_write    (ifid_write),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_next_pc   (out_next_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          rdy;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        mem_q[$];
    ent_t        mq[$];
    logic [31:0] fpc;
    int          epoch;
    int          cyc_n;
    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc_n, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit rst, input bit redir, input logic [31:0] rpc,
                       input bit iw, input bit g, input bit rv_en,
                       input int dly, input bit spur);
        bit   rv;
        logic exp_req;
        logic exp_v;
        ent_t h;
        req_t e;
        @(negedge clock);
        rv = !rst && rv_en && (mem_q.size() > 0) && (mem_q[0].rdy <= cyc_n);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        ifid_write     = iw;
        imem_gnt       = g;
        imem_rvalid    = rv || (!rst && spur && mem_q.size() == 0);
        imem_rdata     = rv ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        exp_req = !rst && !redir && (mem_q.size() < MAXO)
                  && (mq.size() + mem_q.size() < DEPTH);
        exp_v = !rst && (mq.size() > 0);
        h.pc    = 32'h0;
        h.instr = 32'h0;
        if (exp_v) h = mq[0];
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, fpc);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        chk("out_pc", out_pc, h.pc);
        chk("out_instr", out_instr, h.instr);
        chk("out_next_pc", out_next_pc, exp_v ? h.pc + 32'd4 : 32'h0);

        if (rst) begin
            mem_q.delete();
            mq.delete();
            fpc = 32'h0;
            epoch++;
        end else begin
            if (exp_v && iw && !redir) void'(mq.pop_front());
            if (rv) begin
                e = mem_q.pop_front();
                if (!redir && e.epoch == epoch) begin
                    h.pc    = e.addr;
                    h.instr = mem_word(e.addr);
                    mq.push_back(h);
                end
            end
            if (redir) begin
                mq.delete();
                fpc = rpc;
                epoch++;
            end
            if (exp_req && g) begin
                e.addr  = fpc;
                e.epoch = epoch;
                e.rdy   = cyc_n + dly;
                mem_q.push_back(e);
                fpc = fpc + 32'd4;
            end
        end
        cyc_n++;
    endtask

    task automatic run(input int n, input bit iw, input int dly);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, iw, 1, 1, dly, 0);
    endtask

    initial begin
        bit found;
        n_tests = 0;
        n_fail  = 0;
        cyc_n   = 0;
        epoch   = 0;
        fpc     = 32'h0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ifid_write     = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;

        // 1: reset then streaming with single-cycle memory latency
        cyc(1, 0, 0, 1, 1, 1, 1, 0);
        cyc(1, 0, 0, 1, 1, 1, 1, 0);
        run(20, 1, 1);

        // 2: stall for 10 cycles, then release
        run(10, 0, 1);
        run(10, 1, 1);

        // 3: redirect to 0x100 with two fetches in flight
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_q.size() == 2) found = 1;
            else cyc(0, 0, 0, 1, 1, 0, 3, 0);
        end
        chk("p3_setup", 32'(found), 32'd1);
        cyc(0, 1, 32'h100, 1, 1, 0, 1, 0);
        run(15, 1, 1);

        // 4: redirect coinciding with a response and a pop
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mq.size() > 0 && mem_q.size() > 0 && mem_q[0].rdy <= cyc_n)
                found = 1;
            else cyc(0, 0, 0, 1, 1, 1, 1, 0);
        end
        chk("p4_setup", 32'(found), 32'd1);
        cyc(0, 1, 32'h200, 1, 1, 1, 1, 0);
        run(15, 1, 1);

        // 5: grant withheld, then random timing, stalls, redirects, stray responses
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 400; i++) begin
            cyc(0, ($urandom % 20) == 0, $urandom & 32'hFFFF_FFFC,
                ($urandom % 3) != 0, ($urandom % 2) == 0,
                ($urandom % 3) != 0, 1 + int'($urandom % 3),
                ($urandom % 8) == 0);
        end
        run(12, 1, 1);

        // 6: wrap-around at the top of the address space, then mid-stream reset
        cyc(0, 1, 32'hFFFF_FFF8, 1, 1, 1, 1, 0);
        run(10, 1, 1);
        cyc(1, 0, 0, 1, 1, 1, 1, 0);
        run(10, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
